output_writeback: RTL and testbench
===================================

Name: output_writeback

Overview:
- Consumer end of the accelerator output stream.
- Accepts convolution results tagged with (x, y, ch) coordinates and buffers them in a small FIFO.
- Writes each result into external memory at its linear address.
- Signals completion once every output of the feature map has been written.
- Sits between top_system's output port and the external memory write port.

Parameters:
ACCUMULATION_WIDTH, 32, width of each result word
EXT_MEM_HEIGHT, 1<<20, external memory depth in words
EXT_MEM_WIDTH, 32, external memory word width; must equal ACCUMULATION_WIDTH
FEATURE_MAP_WIDTH, 64, output map width
FEATURE_MAP_HEIGHT, 64, output map height
OUTPUT_NB_CHANNELS, 32, output channels
OUT_BASE_ADDR, 0, memory word address of output (0,0,0)
FIFO_DEPTH, 4, entries of the address+data buffer (power of 2, >=2)

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; arms the block for a new layer
output_data  in  ACCUMULATION_WIDTH  result word
output_valid  in  1  result beat valid
output_x  in  $clog2(FEATURE_MAP_WIDTH)  column of the beat
output_y  in  $clog2(FEATURE_MAP_HEIGHT)  row of the beat
output_ch  in  $clog2(OUTPUT_NB_CHANNELS)  channel of the beat
output_ready  out  1  beat accepted when output_valid & output_ready
mem_write_en  out  1  write request
mem_addr  out  $clog2(EXT_MEM_HEIGHT)  write word address
mem_wdata  out  EXT_MEM_WIDTH  write data
mem_ready  in  1  memory accepts the request this cycle
done  out  1  all outputs written; level
write_count  out  $clog2(FW*FH*OC+1)  completed memory writes this layer
range_err  out  1  sticky: out-of-range coordinate seen
protocol_err  out  1  sticky: output_valid seen while not RUN

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset is asynchronous and takes effect mid-operation: the FIFO is flushed, the count is cleared and any pending write is dropped.
- States:
  - IDLE: output_ready=0. start -> RUN.
  - RUN: output_ready = !fifo_full. When write_count reaches TOTAL=FW*FH*OC and the FIFO is empty -> DONE.
  - DONE: done=1, output_ready=0. start -> RUN.
- Entering RUN clears write_count, done, range_err and protocol_err.
- start while in RUN is ignored.
- Address arithmetic: addr = OUT_BASE_ADDR + ((y*FEATURE_MAP_WIDTH + x)*OUTPUT_NB_CHANNELS + ch).
  - Computed at full precision, then truncated to the mem_addr width.
  - Computed combinationally at acceptance and stored in the FIFO alongside the data.
- Range check at acceptance: x >= FW, y >= FH or ch >= OC.
  - The beat is consumed (handshake completes) but is not pushed and not counted.
  - range_err is set.
- output_valid in IDLE or DONE sets protocol_err; the beat is dropped.
- FIFO:
  - Push on an accepted in-range beat.
  - output_ready is driven from registered full status only, so no push occurs when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
- Memory side:
  - mem_write_en = !fifo_empty. mem_addr and mem_wdata show the FIFO head.
  - Values are held stable while mem_write_en & !mem_ready.
  - Pop and write_count++ on mem_write_en & mem_ready.
- Latency: a beat accepted at edge N can be presented on mem_write_en in the cycle following edge N. This is the minimum; there is no combinational path from input to memory port.
- Throughput: 1 write per cycle with mem_ready held high.
- done rises on the edge after the final mem handshake that brings write_count to TOTAL.
- Duplicate coordinates are not detected. They are written and counted, so done may assert early; this is the verifier's concern, not an error flag.

Test Plan:
- Default config: start, one beat x=3, y=2, ch=5, data=0xDEADBEEF, mem_ready=1 -> next cycle mem_write_en=1, mem_addr=4197, mem_wdata=0xDEADBEEF; write_count=1 afterwards.
- OUT_BASE_ADDR=65536, FW=FH=OC=2: stream all 8 beats in raster order with mem_ready=1 -> addresses 65536..65543 in order, done=1 one cycle after the 8th write, write_count=8, state DONE with output_ready=0.
- Backpressure, FIFO_DEPTH=4, mem_ready=0: offer 6 beats -> exactly 4 accepted, output_ready=0. Raise mem_ready -> 4 writes in push order with data intact, then the remaining 2 accepted.
- Out-of-range: config FW=2, beat x=2 -> handshake completes, no mem write, range_err=1 stays set, write_count unchanged. A following start clears range_err.
- Protocol: output_valid=1 in IDLE -> output_ready=0, protocol_err=1, no write.
- Reset mid-run: after 3 of 8 writes with 2 entries in the FIFO, pulse arst -> immediately mem_write_en=0, write_count=0, done=0, state IDLE. A subsequent start plus 8 beats completes normally.

Source files
------------

// File: rtl/output_writeback.sv
// Output writeback: buffers coordinate-tagged results in a small FIFO and writes
// each one to external memory at its linear address, flagging completion per layer.
module output_writeback #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int OUT_BASE_ADDR      = 0,
  parameter int FIFO_DEPTH         = 4,
  localparam int XW    = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW    = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW    = $clog2(OUTPUT_NB_CHANNELS),
  localparam int AW    = $clog2(EXT_MEM_HEIGHT),
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CNTW  = $clog2(TOTAL + 1)
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          start,
  input  logic [ACCUMULATION_WIDTH-1:0] output_data,
  input  logic                          output_valid,
  input  logic [XW-1:0]                 output_x,
  input  logic [YW-1:0]                 output_y,
  input  logic [CW-1:0]                 output_ch,
  output logic                          output_ready,
  output logic                          mem_write_en,
  output logic [AW-1:0]                 mem_addr,
  output logic [EXT_MEM_WIDTH-1:0]      mem_wdata,
  input  logic                          mem_ready,
  output logic                          done,
  output logic [CNTW-1:0]               write_count,
  output logic                          range_err,
  output logic                          protocol_err
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]                 addr_mem [FIFO_DEPTH];
  logic [ACCUMULATION_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [PW:0]                   fifo_cnt;
  logic                          fifo_full, fifo_empty;
  logic                          enter_run, accept, in_range, push, pop;
  logic [AW-1:0]                 addr_calc;

  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign enter_run = start && (state != RUN);
  assign accept    = output_valid && output_ready;
  assign in_range  = ({1'b0, output_x}  < (XW+1)'(FEATURE_MAP_WIDTH)) &&
                     ({1'b0, output_y}  < (YW+1)'(FEATURE_MAP_HEIGHT)) &&
                     ({1'b0, output_ch} < (CW+1)'(OUTPUT_NB_CHANNELS));
  assign push      = accept && in_range;
  assign pop       = mem_write_en && mem_ready;

  // Arithmetic mod 2^AW throughout gives the same bits as truncating the full-precision sum.
  assign addr_calc = AW'(OUT_BASE_ADDR) +
                     (AW'(output_y) * AW'(FEATURE_MAP_WIDTH) + AW'(output_x)) *
                     AW'(OUTPUT_NB_CHANNELS) + AW'(output_ch);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (write_count >= CNTW'(TOTAL) && fifo_empty) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    output_ready = (state == RUN) && !fifo_full;
    done         = (state == DONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= addr_calc;
      data_mem[wr_ptr] <= output_data;
    end
  end

  // Head is gated while empty so stale storage never shows on the memory port.
  assign mem_write_en = !fifo_empty;
  assign mem_addr     = fifo_empty ? '0 : addr_mem[rd_ptr];
  assign mem_wdata    = fifo_empty ? '0 : data_mem[rd_ptr];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      write_count  <= '0;
      range_err    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (enter_run)                          write_count <= '0;
      else if (pop && (write_count != '1))    write_count <= write_count + 1'b1;

      if (enter_run)                 range_err <= 1'b0;
      else if (accept && !in_range)  range_err <= 1'b1;

      if (output_valid && (state != RUN)) protocol_err <= 1'b1;
      else if (enter_run)                 protocol_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_output_writeback.sv
// Scoreboard bench for output_writeback on a small 3x3x2 map with a non-zero base.
module tb_output_writeback;
  localparam int AWD  = 32;
  localparam int MH   = 1 << 20;
  localparam int FW   = 3;
  localparam int FH   = 3;
  localparam int OC   = 2;
  localparam int BASE = 65536;
  localparam int DEP  = 4;
  localparam int XW   = $clog2(FW);
  localparam int YW   = $clog2(FH);
  localparam int CW   = $clog2(OC);
  localparam int AW   = $clog2(MH);
  localparam int TOT  = FW * FH * OC;
  localparam int CNTW = $clog2(TOT + 1);

  logic            clk = 0, arst = 1, start = 0;
  logic [AWD-1:0]  output_data = '0;
  logic            output_valid = 0;
  logic [XW-1:0]   output_x = '0;
  logic [YW-1:0]   output_y = '0;
  logic [CW-1:0]   output_ch = '0;
  logic            output_ready, mem_write_en, mem_ready = 1, done, range_err, protocol_err;
  logic [AW-1:0]   mem_addr;
  logic [AWD-1:0]  mem_wdata;
  logic [CNTW-1:0] write_count;

  output_writeback #(
    .ACCUMULATION_WIDTH(AWD), .EXT_MEM_HEIGHT(MH), .EXT_MEM_WIDTH(AWD),
    .FEATURE_MAP_WIDTH(FW), .FEATURE_MAP_HEIGHT(FH), .OUTPUT_NB_CHANNELS(OC),
    .OUT_BASE_ADDR(BASE), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .arst(arst), .start(start), .output_data(output_data),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch), .output_ready(output_ready), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .done(done),
    .write_count(write_count), .range_err(range_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [AWD-1:0] data; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int x, input int y, input int ch);
    longint a;
    a = longint'(BASE) + ((longint'(y) * FW + x) * OC + ch);
    return a[AW-1:0];
  endfunction

  // Offers one beat starting now (posedge+1 phase); returns at posedge+1 after acceptance.
  task automatic send_beat(input int x, input int y, input int ch, input logic [AWD-1:0] d);
    bit ok = 0;
    exp_t e;
    output_valid = 1;
    output_x = XW'(x); output_y = YW'(y); output_ch = CW'(ch); output_data = d;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (output_ready) begin
        ok = 1;
        if (x < FW && y < FH && ch < OC) begin
          e.addr = exp_addr(x, y, ch);
          e.data = d;
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    output_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_idx(input int i);
    send_beat((i / OC) % FW, i / (OC * FW), i % OC, $urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  always @(negedge clk) begin
    if (!arst && mem_write_en && mem_ready) begin
      if (sb.size() == 0) chk("unexpected_write", {32'b0, mem_addr}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 arst = 0;
    @(negedge clk);
    chk("rst_ready", output_ready, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_count", write_count, 0);
    chk("rst_rerr", range_err, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_addr", mem_addr, 0);

    // valid while IDLE
    @(posedge clk); #1 output_valid = 1;
    @(negedge clk); chk("idle_ready", output_ready, 0);
    @(posedge clk); #1 output_valid = 0;
    @(negedge clk);
    chk("idle_perr", protocol_err, 1);
    chk("idle_no_we", mem_write_en, 0);

    pulse_start();
    @(negedge clk);
    chk("run_perr_clr", protocol_err, 0);
    chk("run_ready", output_ready, 1);

    // single beat, minimum latency
    @(posedge clk); #1;
    send_beat(2, 1, 1, 32'hDEADBEEF);
    @(negedge clk); chk("latency_we", mem_write_en, 1);
    @(negedge clk); chk("count_1", write_count, 1);

    pulse_start();
    @(negedge clk); chk("start_in_run", write_count, 1);

    @(posedge clk); #1;
    send_beat(0, 0, 0, 32'h11);
    send_beat(1, 0, 0, 32'h22);
    repeat (3) @(posedge clk);
    @(negedge clk); chk("count_3", write_count, 3);

    // stall two beats then reset asynchronously
    @(posedge clk); #1 mem_ready = 0;
    send_beat(0, 1, 0, 32'h33);
    send_beat(1, 1, 0, 32'h44);
    @(negedge clk);
    chk("pre_rst_we", mem_write_en, 1);
    #2 arst = 1;
    #1;
    chk("arst_we", mem_write_en, 0);
    chk("arst_count", write_count, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", output_ready, 0);
    sb.delete();
    mem_ready = 1;
    @(posedge clk); #1 arst = 0;

    pulse_start();
    @(posedge clk); #1;
    send_beat(3, 0, 0, 32'h55);
    send_beat(0, 3, 1, 32'h66);
    @(negedge clk);
    chk("oor_rerr", range_err, 1);
    chk("oor_no_we", mem_write_en, 0);
    chk("oor_count", write_count, 0);

    // backpressure: FIFO fills at DEP entries, head held
    @(posedge clk); #1 mem_ready = 0;
    for (int i = 0; i < DEP; i++) send_idx(i);
    output_valid = 1; output_x = '0; output_y = YW'(1); output_ch = '0;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", output_ready, 0);
      chk("held_addr", mem_addr, exp_addr(0, 0, 0));
    end
    @(posedge clk); #1 mem_ready = 1;
    for (int i = DEP; i < TOT; i++) send_idx(i);

    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (write_count == CNTW'(TOT)) seen = 1;
    end
    chk("count_total", seen, 1);
    chk("done_not_yet", done, 0);
    @(negedge clk);
    chk("done_level", done, 1);
    chk("done_ready", output_ready, 0);
    chk("done_count", write_count, TOT);
    chk("sb_empty", sb.size(), 0);
    chk("rerr_sticky", range_err, 1);

    @(posedge clk); #1 output_valid = 1;
    @(posedge clk); #1 output_valid = 0;
    @(negedge clk);
    chk("done_perr", protocol_err, 1);
    chk("done_no_we", mem_write_en, 0);

    pulse_start();
    @(negedge clk);
    chk("rearm_rerr", range_err, 0);
    chk("rearm_perr", protocol_err, 0);
    chk("rearm_done", done, 0);
    chk("rearm_count", write_count, 0);
    chk("rearm_ready", output_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
